frog_controller: RTL

- Player-side consumer of the 16x16 lane bitmaps produced by the car controller.
- Holds the frog position and takes direction key edges.
- Checks the frog's cell against the live lane bitmap every cycle.
- Runs the game FSM (idle/play/hit/over) and reports score and lives to the display and HEX logic.

---
 rtl/frog_pkg.sv | 12 +
 rtl/frog_controller_key_edge.sv | 14 +
 rtl/frog_controller.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/frog_pkg.sv
// frog_pkg: shared game states, grid geometry and lane-bitmap lookup for the frog controller.
package frog_pkg;
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HIT, S_OVER} frog_state_t;
    localparam int GRID_ROWS = 16;
    localparam int GRID_COLS = 16;
    localparam logic [7:0] SCORE_MAX = 8'd255;
    // Row r occupies lanes[r*16 +: 16], so the flat bit index is simply {row, col}.
    function automatic logic lane_bit(input logic [GRID_ROWS*GRID_COLS-1:0] lanes,
                                      input logic [3:0] row, input logic [3:0] col);
        return lanes[{row, col}];
    endfunction
endpackage

// File: rtl/frog_controller_key_edge.sv
// key_edge: rising-edge detector on a debounced key level; history clears on reset.
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_pulse
);
    logic r_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= 1'b0;
        else        r_q <= i_level;
    end
    assign o_pulse = i_level & ~r_q;
endmodule

// File: rtl/frog_controller.sv
// frog_controller: frog position, lane collision check and idle/play/hit/over game FSM.
// Optional build macro FROG_INVINCIBLE_EN disables collisions for lane-timing bring-up.
module frog_controller
    import frog_pkg::*;
#(
    parameter logic [3:0] START_COL   = 4'd7,
    parameter logic [1:0] START_LIVES = 2'd3,
    parameter int         HIT_HOLD    = 1000,
    parameter logic [3:0] GOAL_ROW    = 4'd15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           up,
    input  logic                           down,
    input  logic                           left,
    input  logic                           right,
    input  logic [GRID_ROWS*GRID_COLS-1:0] lanes,
    output logic [3:0]                     player_row,
    output logic [3:0]                     player_col,
    output logic [7:0]                     score,
    output logic [1:0]                     lives,
    output logic                           hit,
    output logic                           win,
    output logic                           game_over,
    output logic                           frozen
);
    localparam int CW = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
    localparam logic [3:0] ROW_MAX = 4'(GRID_ROWS - 1);
    localparam logic [3:0] COL_MAX = 4'(GRID_COLS - 1);
`ifdef FROG_INVINCIBLE_EN
    localparam bit INVINCIBLE = 1'b1;
`else
    localparam bit INVINCIBLE = 1'b0;
`endif

    frog_state_t r_state, w_state_nx;
    logic [3:0]    r_row, r_col, w_row_nx, w_col_nx;
    logic [7:0]    r_score, w_score_nx;
    logic [1:0]    r_lives, w_lives_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          r_hit, r_win, r_game_over, r_frozen, w_hit_nx, w_win_nx;
    logic          w_start, w_up, w_down, w_left, w_right;
    logic          w_coll, w_hold_done, w_one_move;

    key_edge u_start (.clk(clk), .rst_n(reset), .i_level(start), .o_pulse(w_start));
    key_edge u_up    (.clk(clk), .rst_n(reset), .i_level(up),    .o_pulse(w_up));
    key_edge u_down  (.clk(clk), .rst_n(reset), .i_level(down),  .o_pulse(w_down));
    key_edge u_left  (.clk(clk), .rst_n(reset), .i_level(left),  .o_pulse(w_left));
    key_edge u_right (.clk(clk), .rst_n(reset), .i_level(right), .o_pulse(w_right));

    assign w_coll      = !INVINCIBLE && (r_state == S_PLAY) && lane_bit(lanes, r_row, r_col);
    assign w_hold_done = (r_cnt == CW'(HIT_HOLD - 1));
    assign w_one_move  = $onehot({w_up, w_down, w_left, w_right});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  w_state_nx = w_start ? S_PLAY : S_IDLE;
            S_PLAY:  w_state_nx = w_start ? S_PLAY : (w_coll ? S_HIT : S_PLAY);
            S_HIT:   w_state_nx = w_start ? S_PLAY :
                                  (w_hold_done ? ((r_lives != 2'd0) ? S_PLAY : S_OVER) : S_HIT);
            default: w_state_nx = w_start ? S_PLAY : S_OVER;
        endcase
    end

    // Collision beats crossing, crossing beats movement; start overrides everything.
    always_comb begin
        w_row_nx   = r_row;
        w_col_nx   = r_col;
        w_score_nx = r_score;
        w_lives_nx = r_lives;
        w_hit_nx   = 1'b0;
        w_win_nx   = 1'b0;
        w_cnt_nx   = '0;
        if (w_start) begin
            w_row_nx   = 4'd0;
            w_col_nx   = START_COL;
            w_score_nx = 8'd0;
            w_lives_nx = START_LIVES;
        end else if (r_state == S_PLAY) begin
            if (w_coll) begin
                w_hit_nx   = 1'b1;
                w_lives_nx = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
            end else if (r_row == GOAL_ROW) begin
                w_win_nx   = 1'b1;
                w_score_nx = (r_score == SCORE_MAX) ? SCORE_MAX : r_score + 8'd1;
                w_row_nx   = 4'd0;
                w_col_nx   = START_COL;
            end else if (w_one_move) begin
                w_row_nx = w_up   ? ((r_row == ROW_MAX) ? r_row : r_row + 4'd1) :
                           w_down ? ((r_row == 4'd0)    ? r_row : r_row - 4'd1) : r_row;
                w_col_nx = w_right ? ((r_col == COL_MAX) ? r_col : r_col + 4'd1) :
                           w_left  ? ((r_col == 4'd0)    ? r_col : r_col - 4'd1) : r_col;
            end
        end else if (r_state == S_HIT) begin
            w_cnt_nx = w_hold_done ? '0 : r_cnt + CW'(1);
            if (w_hold_done && r_lives != 2'd0) begin
                w_row_nx = 4'd0;
                w_col_nx = START_COL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row       <= 4'd0;
            r_col       <= START_COL;
            r_score     <= 8'd0;
            r_lives     <= START_LIVES;
            r_cnt       <= '0;
            r_hit       <= 1'b0;
            r_win       <= 1'b0;
            r_game_over <= 1'b0;
            r_frozen    <= 1'b0;
        end else begin
            r_row       <= w_row_nx;
            r_col       <= w_col_nx;
            r_score     <= w_score_nx;
            r_lives     <= w_lives_nx;
            r_cnt       <= w_cnt_nx;
            r_hit       <= w_hit_nx;
            r_win       <= w_win_nx;
            r_game_over <= (w_state_nx == S_OVER);
            r_frozen    <= (w_state_nx == S_HIT);
        end
    end

    assign player_row = r_row;
    assign player_col = r_col;
    assign score      = r_score;
    assign lives      = r_lives;
    assign hit        = r_hit;
    assign win        = r_win;
    assign game_over  = r_game_over;
    assign frozen     = r_frozen;
endmodule
